// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - control sequencer handshake/strobe bundle
// master = sequencer (drives strobes), slave = datapath/memory side.
interface control_sequencer_if #(
  parameter int REG_BITS = 4,
  parameter int OPC_BITS = 5,
  parameter int CNT_W    = 16
);
  localparam int NREGS = 2 ** REG_BITS;

  logic                Run;
  logic                MemReady;
  logic [31:0]         IR;
  logic                PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin;
  logic                Read, MDRin, MDRout, IRin, Yin, HIin, LOin;
  logic [NREGS-1:0]    Rin;
  logic [NREGS-1:0]    Rout;
  logic [OPC_BITS-1:0] AluOp;
  logic                Halted;
  logic                Illegal;
  logic [CNT_W-1:0]    InstrCount;
  logic [3:0]          State;

  modport master (
    input  Run, MemReady, IR,
    output PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin,
    output Read, MDRin, MDRout, IRin, Yin, HIin, LOin,
    output Rin, Rout, AluOp, Halted, Illegal, InstrCount, State
  );

  modport slave (
    output Run, MemReady, IR,
    input  PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin,
    input  Read, MDRin, MDRout, IRin, Yin, HIin, LOin,
    input  Rin, Rout, AluOp, Halted, Illegal, InstrCount, State
  );
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/decode/execute control sequencer
// Optional MUL/DIV sequencing enabled by macro CONTROL_SEQUENCER_MULDIV_EN.
module control_sequencer #(
  parameter int REG_BITS = 4,
  parameter int OPC_BITS = 5,
  parameter int CNT_W    = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  control_sequencer_if.master  bus
);
  localparam int NREGS  = 2 ** REG_BITS;
  localparam int RA_HI  = 31 - OPC_BITS;
  localparam int RB_HI  = RA_HI - REG_BITS;
  localparam int RC_HI  = RB_HI - REG_BITS;
  localparam int LOW_HI = RC_HI - REG_BITS;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_HALT = 4'd8
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;

  logic [OPC_BITS-1:0] w_opc;
  logic [REG_BITS-1:0] w_ra, w_rb, w_rc;
  logic                w_is_alu, w_is_muldiv, w_is_nop, w_is_halt, w_is_illegal;
  logic                w_unused_ir;

  assign w_opc = bus.IR[31 -: OPC_BITS];
  assign w_ra  = bus.IR[RA_HI -: REG_BITS];
  assign w_rb  = bus.IR[RB_HI -: REG_BITS];
  assign w_rc  = bus.IR[RC_HI -: REG_BITS];
  assign w_unused_ir = ^bus.IR[LOW_HI:0];

  assign w_is_alu  = (w_opc >= OPC_BITS'(3)) && (w_opc <= OPC_BITS'(11));
  assign w_is_nop  = (w_opc == OPC_BITS'(26));
  assign w_is_halt = (w_opc == OPC_BITS'(27));
`ifdef CONTROL_SEQUENCER_MULDIV_EN
  assign w_is_muldiv = (w_opc == OPC_BITS'(15)) || (w_opc == OPC_BITS'(16));
`else
  assign w_is_muldiv = 1'b0;
`endif
  assign w_is_illegal = !(w_is_alu || w_is_muldiv || w_is_nop || w_is_halt);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.Run) r_state <= S_T0;
        S_T0:   r_state <= S_T1;
        S_T1:   if (bus.MemReady) r_state <= S_T2;
        S_T2:   r_state <= S_T3;
        S_T3: begin
          if (w_is_alu || w_is_muldiv) begin
            r_state <= S_T4;
          end else if (w_is_nop) begin
            r_state <= S_IDLE;
            r_count <= r_count + CNT_W'(1);
          end else if (w_is_halt) begin
            r_state <= S_HALT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_T4:   r_state <= S_T5;
        S_T5: begin
          if (w_is_muldiv) begin
            r_state <= S_T6;
          end else begin
            r_state <= S_IDLE;
            r_count <= r_count + CNT_W'(1);
          end
        end
        S_T6: begin
          r_state <= S_IDLE;
          r_count <= r_count + CNT_W'(1);
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  logic                w_pcout, w_marin, w_incpc, w_zin, w_zloout, w_zhiout, w_pcin;
  logic                w_read, w_mdrin, w_mdrout, w_irin, w_yin, w_hiin, w_loin;
  logic [NREGS-1:0]    w_rin, w_rout;
  logic [OPC_BITS-1:0] w_aluop;

  // Strobes decode from the registered state; T1 completion follows MemReady in-cycle.
  always_comb begin
    w_pcout = 1'b0; w_marin = 1'b0; w_incpc = 1'b0; w_zin  = 1'b0;
    w_zloout = 1'b0; w_zhiout = 1'b0; w_pcin = 1'b0; w_read = 1'b0;
    w_mdrin = 1'b0; w_mdrout = 1'b0; w_irin = 1'b0; w_yin  = 1'b0;
    w_hiin  = 1'b0; w_loin   = 1'b0;
    w_rin   = '0;   w_rout   = '0;   w_aluop = '0;
    case (r_state)
      S_T0: begin
        w_pcout = 1'b1; w_marin = 1'b1; w_incpc = 1'b1; w_zin = 1'b1;
      end
      S_T1: begin
        w_read   = 1'b1;
        w_mdrin  = 1'b1;
        w_zloout = bus.MemReady;
        w_pcin   = bus.MemReady;
      end
      S_T2: begin
        w_mdrout = 1'b1;
        w_irin   = 1'b1;
      end
      S_T3: begin
        if (w_is_alu || w_is_muldiv) begin
          w_rout = NREGS'(1) << w_rb;
          w_yin  = 1'b1;
        end
      end
      S_T4: begin
        w_rout  = NREGS'(1) << (w_is_muldiv ? w_ra : w_rc);
        w_zin   = 1'b1;
        w_aluop = w_opc;
      end
      S_T5: begin
        w_zloout = 1'b1;
        if (!w_is_muldiv) w_rin = NREGS'(1) << w_ra;
`ifdef CONTROL_SEQUENCER_MULDIV_EN
        else w_loin = 1'b1;
`endif
      end
      S_T6: begin
`ifdef CONTROL_SEQUENCER_MULDIV_EN
        w_zhiout = 1'b1;
        w_hiin   = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  assign bus.PCout  = w_pcout;
  assign bus.MARin  = w_marin;
  assign bus.IncPC  = w_incpc;
  assign bus.Zin    = w_zin;
  assign bus.ZLOout = w_zloout;
  assign bus.ZHIout = w_zhiout;
  assign bus.PCin   = w_pcin;
  assign bus.Read   = w_read;
  assign bus.MDRin  = w_mdrin;
  assign bus.MDRout = w_mdrout;
  assign bus.IRin   = w_irin;
  assign bus.Yin    = w_yin;
  assign bus.HIin   = w_hiin;
  assign bus.LOin   = w_loin;
  assign bus.Rin    = w_rin;
  assign bus.Rout   = w_rout;
  assign bus.AluOp  = w_aluop;

  assign bus.Halted     = (r_state == S_HALT);
  assign bus.Illegal    = (r_state == S_T3) && w_is_illegal;
  assign bus.InstrCount = r_count;
  assign bus.State      = r_state;
endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - randomized trace-model bench for control_sequencer
module tb_control_sequencer;
  localparam int REG_BITS = 4;
  localparam int OPC_BITS = 5;
  localparam int CNT_W    = 4;
`ifdef CONTROL_SEQUENCER_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  localparam logic [3:0] IDLE = 4'd0, T0 = 4'd1, T1 = 4'd2, T2 = 4'd3, T3 = 4'd4;
  localparam logic [3:0] T4 = 4'd5, T5 = 4'd6, T6 = 4'd7, HALT = 4'd8;

  localparam logic [13:0] PCOUT = 14'h2000, MARIN = 14'h1000, INCPC = 14'h0800;
  localparam logic [13:0] ZIN = 14'h0400, ZLOOUT = 14'h0200, ZHIOUT = 14'h0100;
  localparam logic [13:0] PCIN = 14'h0080, READ = 14'h0040, MDRIN = 14'h0020;
  localparam logic [13:0] MDROUT = 14'h0010, IRIN = 14'h0008, YIN = 14'h0004;
  localparam logic [13:0] HIIN = 14'h0002, LOIN = 14'h0001;

  typedef struct packed {
    logic [3:0]  st;
    logic [13:0] sb;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  alu;
    logic        illegal;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;

  always #5 Clock = ~Clock;

  control_sequencer_if #(.REG_BITS(REG_BITS), .OPC_BITS(OPC_BITS), .CNT_W(CNT_W)) bus ();

  control_sequencer #(.REG_BITS(REG_BITS), .OPC_BITS(OPC_BITS), .CNT_W(CNT_W)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  logic [13:0] obs_sb;
  assign obs_sb = {bus.PCout, bus.MARin, bus.IncPC, bus.Zin, bus.ZLOout, bus.ZHIout,
                   bus.PCin, bus.Read, bus.MDRin, bus.MDRout, bus.IRin, bus.Yin,
                   bus.HIin, bus.LOin};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] st, input logic [13:0] sb);
    exp_t e;
    e = '0;
    e.st = st;
    e.sb = sb;
    return e;
  endfunction

  // Expected per-cycle trace of one instruction, starting at its IDLE launch cycle.
  task automatic run_instr(input logic [31:0] ir, input int waits);
    exp_t tr[$];
    exp_t e;
    int   op, ra, rb, rc, t1_seen;
    bit   alu, md, nop, hlt;
    string tg;
    op = int'(ir[31:27]);
    ra = int'(ir[26:23]);
    rb = int'(ir[22:19]);
    rc = int'(ir[18:15]);
    alu = (op >= 3) && (op <= 11);
    md  = MULDIV && (op == 15 || op == 16);
    nop = (op == 26);
    hlt = (op == 27);
    tr.push_back(mk(IDLE, 14'h0));
    tr.push_back(mk(T0, PCOUT | MARIN | INCPC | ZIN));
    for (int i = 0; i < waits; i++) tr.push_back(mk(T1, READ | MDRIN));
    tr.push_back(mk(T1, READ | MDRIN | ZLOOUT | PCIN));
    tr.push_back(mk(T2, MDROUT | IRIN));
    e = mk(T3, 14'h0);
    if (alu || md) begin
      e.sb   = YIN;
      e.rout = 16'(1) << rb;
    end else if (!nop && !hlt) begin
      e.illegal = 1'b1;
    end
    tr.push_back(e);
    if (alu || md) begin
      e = mk(T4, ZIN);
      e.alu  = 5'(op);
      e.rout = 16'(1) << (alu ? rc : ra);
      tr.push_back(e);
      e = mk(T5, ZLOOUT);
      if (alu) e.rin = 16'(1) << ra;
      else     e.sb  = e.sb | LOIN;
      tr.push_back(e);
      if (md) tr.push_back(mk(T6, ZHIOUT | HIIN));
    end
    t1_seen = 0;
    for (int k = 0; k < tr.size(); k++) begin
      bus.IR  = ir;
      bus.Run = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (tr[k].st == T1) begin
        bus.MemReady = (t1_seen == waits);
        t1_seen++;
      end else begin
        bus.MemReady = 1'($urandom_range(0, 1));
      end
      #1;
      tg = $sformatf("ir%08h_c%0d", ir, k);
      chk({tg, "_state"},   {28'h0, bus.State},   {28'h0, tr[k].st});
      chk({tg, "_strobes"}, {18'h0, obs_sb},      {18'h0, tr[k].sb});
      chk({tg, "_rin"},     {16'h0, bus.Rin},     {16'h0, tr[k].rin});
      chk({tg, "_rout"},    {16'h0, bus.Rout},    {16'h0, tr[k].rout});
      chk({tg, "_aluop"},   {27'h0, bus.AluOp},   {27'h0, tr[k].alu});
      chk({tg, "_illegal"}, {31'h0, bus.Illegal}, {31'h0, tr[k].illegal});
      chk({tg, "_halted"},  {31'h0, bus.Halted},  32'h0);
      @(posedge Clock);
      #1;
    end
    if (alu || md || nop) model_cnt = (model_cnt + 1) % (1 << CNT_W);
    chk($sformatf("ir%08h_count", ir), {28'h0, bus.InstrCount}, 32'(model_cnt));
  endtask

  initial begin
    logic [31:0] ir;
    int          start_cnt;
    Reset = 1'b1;
    bus.Run = 1'b0;
    bus.MemReady = 1'b0;
    bus.IR = 32'h0;
    repeat (2) @(posedge Clock);
    #1;
    chk("reset_state",   {28'h0, bus.State},      {28'h0, IDLE});
    chk("reset_count",   {28'h0, bus.InstrCount}, 32'h0);
    chk("reset_strobes", {18'h0, obs_sb},         32'h0);
    chk("reset_halted",  {31'h0, bus.Halted},     32'h0);
    chk("reset_illegal", {31'h0, bus.Illegal},    32'h0);
    Reset = 1'b0;

    run_instr(32'h2891_8000, 0);
    run_instr(32'h2891_8000, 3);
    run_instr({5'd15, 4'd4, 4'd5, 4'd0, 15'h0}, 0);
    run_instr({5'd16, 4'd9, 4'd15, 4'd2, 15'h1234}, 2);
    run_instr({5'd3, 4'd0, 4'd15, 4'd15, 15'h0}, 1);
    run_instr({5'd11, 4'd15, 4'd0, 4'd7, 15'h7fff}, 0);
    run_instr({5'd26, 27'h0}, 0);
    run_instr({5'd31, 27'h0}, 0);
    run_instr({5'd0, 27'h5a5a5a5}, 1);

    for (int n = 0; n < 40; n++) begin
      ir = $urandom;
      if (ir[31:27] == 5'd27) ir[31:27] = 5'd26;
      run_instr(ir, int'($urandom_range(0, 3)));
    end

    start_cnt = model_cnt;
    for (int n = 0; n < 16; n++) run_instr({5'd26, 27'(n)}, 0);
    chk("nop_wrap_count", {28'h0, bus.InstrCount}, 32'(start_cnt));

    run_instr({5'd5, 4'd1, 4'd2, 4'd3, 15'h0}, 0);
    bus.Run = 1'b1;
    bus.MemReady = 1'b0;
    bus.IR = 32'h2891_8000;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    chk("t1wait_state", {28'h0, bus.State}, {28'h0, T1});
    bus.Run = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    chk("t1reset_state",   {28'h0, bus.State},      {28'h0, IDLE});
    chk("t1reset_strobes", {18'h0, obs_sb},         32'h0);
    chk("t1reset_count",   {28'h0, bus.InstrCount}, 32'h0);
    model_cnt = 0;

    run_instr(32'h2891_8000, 0);
    run_instr({5'd27, 27'h0}, 1);
    for (int n = 0; n < 10; n++) begin
      bus.Run = ~bus.Run;
      bus.MemReady = 1'($urandom_range(0, 1));
      #1;
      chk($sformatf("halt_state_%0d", n),   {28'h0, bus.State},  {28'h0, HALT});
      chk($sformatf("halt_halted_%0d", n),  {31'h0, bus.Halted}, 32'h1);
      chk($sformatf("halt_strobes_%0d", n), {18'h0, obs_sb},     32'h0);
      @(posedge Clock); #1;
    end
    chk("halt_count", {28'h0, bus.InstrCount}, 32'(model_cnt));
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    bus.Run = 1'b0;
    chk("halt_reset_state",  {28'h0, bus.State},  {28'h0, IDLE});
    chk("halt_reset_halted", {31'h0, bus.Halted}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameters SHALL be: REG_BITS, default 4, register-field width (NREGS = 2**REG_BITS); OPC_BITS, default 5, opcode width; CNT_W, default 16, retired-instruction counter width.
REQ-002 Ports SHALL be: Clock  in  1  rising-edge clock; Reset  in  1  synchronous, active-high reset.
REQ-003 Run  in  1  permits a new fetch; MemReady  in  1  memory read data valid; IR  in  32  instruction register contents.
REQ-004 PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin, Read, MDRin, MDRout, IRin, Yin, HIin, LOin  out  1 each  datapath strobes.
REQ-005 Rin, Rout  out  NREGS  one-hot register load/drive selects; AluOp  out  OPC_BITS  ALU operation.
REQ-006 Halted  out  1; Illegal  out  1  one-cycle pulse; InstrCount  out  CNT_W  retired instructions; State  out  4  current state.

Function
REQ-007 IR fields SHALL be: opcode IR[31:32-OPC_BITS]; Ra, Rb and Rc SHALL be consecutive REG_BITS fields immediately below the opcode. With defaults, 0x28918000 decodes as opcode 5, Ra=1, Rb=2, Rc=3.
REQ-008 Opcode classes SHALL be: 3..11 ALU three-register (Ra <= Rb op Rc); 15 MUL and 16 DIV (HI/LO <= Ra op Rb); 26 NOP; 27 HALT; all others illegal.
REQ-009 States SHALL be IDLE, T0, T1, T2, T3, T4, T5, T6, HALT; all outputs not listed for a state SHALL be 0.
REQ-010 IDLE: no strobes asserted; go to T0 when Run=1, otherwise stay in IDLE.
REQ-011 T0: PCout, MARin, IncPC, Zin; go to T1.
REQ-012 T1: Read and MDRin asserted every cycle. ZLOout and PCin asserted only in the cycle MemReady=1, and that cycle goes to T2. While MemReady=0 the state SHALL stay in T1 with no limit.
REQ-013 T2: MDRout, IRin; go to T3.
REQ-014 T3, decoded from IR: ALU/MUL/DIV assert Rout[Rb] and Yin, then go to T4. NOP goes to IDLE and retires. HALT goes to HALT. Illegal pulses Illegal for one cycle and goes to IDLE without retiring.
REQ-015 T4: ALU asserts Rout[Rc]; MUL/DIV asserts Rout[Ra]. Both assert Zin with AluOp=opcode; go to T5.
REQ-016 T5: ALU asserts ZLOout and Rin[Ra], retires, and goes to IDLE. MUL/DIV asserts ZLOout and LOin, then goes to T6.
REQ-017 T6: ZHIout, HIin; retire; go to IDLE.
REQ-018 AluOp SHALL be 0 outside T4.
REQ-019 Rin and Rout SHALL each have at most one bit set in any cycle.
REQ-020 Retire SHALL increment InstrCount by 1 in the same cycle as the transition; the count wraps from 2**CNT_W-1 to 0.
REQ-021 Latency with MemReady already 1 at T1: ALU 6 cycles T0..T5; MUL/DIV 7 cycles; NOP 4 cycles.
REQ-022 Run is sampled only in IDLE; deasserting Run mid-instruction SHALL NOT abort the instruction.
REQ-023 HALT: Halted=1 and no strobes; HALT is exited only by Reset.

Reset
REQ-024 On Reset=1 at a rising Clock edge: State=IDLE, InstrCount=0, Halted=0, Illegal=0, all strobes 0. This holds in every state, including T1 wait cycles and T6.
REQ-025 Reset SHALL take priority over every other input.

Configuration
REQ-026 Macro CONTROL_SEQUENCER_MULDIV_EN: when defined, opcodes 15 and 16 follow REQ-015 to REQ-017. When undefined, they are illegal per REQ-014, T6 is unreachable, and HIin, LOin and ZHIout are tied to 0.

Verification
REQ-027 Reset, Run=1, MemReady=1, IR=0x28918000 -> T0..T5 strobes per REQ-011 to REQ-016; Rout=0x0004 at T3, Rout=0x0008 at T4, AluOp=5 at T4, Rin=0x0002 at T5; InstrCount=1 after 6 cycles.
REQ-028 Same instruction with MemReady held 0 for 3 cycles in T1 -> State=T1 for 4 cycles; PCin and ZLOout asserted only in the 4th; total 9 cycles.
REQ-029 IR opcode 15 with Ra=4, Rb=5, macro defined -> T4 Rout=0x0010, T5 LOin=1, T6 HIin=1 and ZHIout=1; 7 cycles. Macro undefined -> Illegal pulse at T3, InstrCount unchanged.
REQ-030 IR opcode 27 -> Halted=1 after T3; Run toggled for 10 cycles leaves State=HALT; Reset returns State=IDLE and Halted=0.
REQ-031 Reset asserted during a T1 wait -> next cycle State=IDLE, all strobes 0, InstrCount=0.
REQ-032 CNT_W=4, 16 NOPs -> InstrCount wraps from 15 to 0; illegal opcode 31 -> one-cycle Illegal pulse.
